// File: rtl/dsp_goertzel_trig_server.sv
// rtl/dsp_goertzel_trig_server.sv - Goertzel trig-coefficient responder with writable bin table
//
// Purpose: holds a per-bin (sin, cos) table in signed Q2.14 and presents the current bin's pair.
//          Each request_trig consumes the presented pair and advances the sweep index, which wraps
//          after num_runs requests or at the last table entry.
// Ports:
//   sys_clk, sys_rst           clock, asynchronous active-high reset
//   request_trig               consume presented pair (one per high cycle)
//   num_runs                   bins per frame
//   seq_restart                restart sweep at bin 0 (wins over request_trig)
//   cfg_we/cfg_addr/cfg_sin/cfg_cos   table write port
//   sin_out, cos_out           presented pair (registered)
//   coeff_valid                presented pair matches table[idx]
//   bin_tag                    index of the last consumed pair
//   req_overrun                sticky flag: request seen while coeff_valid was low
module dsp_goertzel_trig_server #(
  parameter int NUM_BINS = 32,
  parameter int BIN_BITS = 5,
  parameter int C_W      = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                request_trig,
  input  logic [4:0]          num_runs,
  input  logic                seq_restart,
  input  logic                cfg_we,
  input  logic [BIN_BITS-1:0] cfg_addr,
  input  logic [C_W-1:0]      cfg_sin,
  input  logic [C_W-1:0]      cfg_cos,
  output logic [C_W-1:0]      sin_out,
  output logic [C_W-1:0]      cos_out,
  output logic                coeff_valid,
  output logic [BIN_BITS-1:0] bin_tag,
  output logic                req_overrun
);

  logic [C_W-1:0]      sin_tab [NUM_BINS];
  logic [C_W-1:0]      cos_tab [NUM_BINS];
  logic [BIN_BITS-1:0] idx;
  logic [BIN_BITS-1:0] idx_nxt;
  logic [4:0]          run_cnt;
  logic [4:0]          run_nxt;
  logic                reload_pend;
  logic                req_take;
  logic                wrap;
  logic                addr_ok;
  logic                cfg_hit;
  logic                invalidate;

  always_comb begin
    req_take = request_trig && !seq_restart;
    // num_runs == 0 makes the compare always true, so every request wraps.
    wrap     = (({1'b0, run_cnt} + 6'd1) >= {1'b0, num_runs}) ||
               (idx == BIN_BITS'(NUM_BINS - 1));
    idx_nxt  = idx;
    run_nxt  = run_cnt;
    if (seq_restart) begin
      idx_nxt = '0;
      run_nxt = '0;
    end else if (req_take) begin
      if (wrap) begin
        idx_nxt = '0;
        run_nxt = '0;
      end else begin
        idx_nxt = idx + 1'b1;
        run_nxt = run_cnt + 5'd1;
      end
    end
    addr_ok    = ({1'b0, cfg_addr} < (BIN_BITS + 1)'(NUM_BINS));
    // A write landing on the index we will present next makes the output stale.
    cfg_hit    = cfg_we && addr_ok && (cfg_addr == idx_nxt);
    invalidate = seq_restart || req_take || cfg_hit;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_BINS; i++) begin
        sin_tab[i] <= '0;
        cos_tab[i] <= '0;
      end
    end else if (cfg_we && addr_ok) begin
      sin_tab[cfg_addr] <= cfg_sin;
      cos_tab[cfg_addr] <= cfg_cos;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx         <= '0;
      run_cnt     <= '0;
      sin_out     <= '0;
      cos_out     <= '0;
      coeff_valid <= 1'b0;
      bin_tag     <= '0;
      req_overrun <= 1'b0;
      reload_pend <= 1'b1;
    end else begin
      idx     <= idx_nxt;
      run_cnt <= run_nxt;
      if (seq_restart) begin
        req_overrun <= 1'b0;
      end else if (req_take) begin
        bin_tag <= idx;
        if (!coeff_valid) begin
          req_overrun <= 1'b1;
        end
      end
      // Any disturbance defers the reload by one edge so the reload always sees the
      // post-write table and the final index; outputs stay put through a request edge.
      if (invalidate) begin
        coeff_valid <= 1'b0;
        reload_pend <= 1'b1;
      end else if (reload_pend) begin
        sin_out     <= sin_tab[idx];
        cos_out     <= cos_tab[idx];
        coeff_valid <= 1'b1;
        reload_pend <= 1'b0;
      end
    end
  end

endmodule
